// File: rtl/bitwise_accel_pkg.sv
// Shared constants, types and reduction helpers for the bitwise reduction accelerator.
package bitwise_accel_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COUNT_W = 8;

    // Register byte offsets.
    localparam logic [7:0] OFF_CTRL   = 8'h80;
    localparam logic [7:0] OFF_STATUS = 8'h84;
    localparam logic [7:0] OFF_RESULT = 8'h88;

    // CTRL field positions.
    localparam int unsigned CTRL_START_BIT  = 0;
    localparam int unsigned CTRL_MODE_LSB   = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT = 3;
    localparam int unsigned CTRL_COUNT_LSB  = 8;

    // STATUS field positions.
    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_DONE_BIT = 1;
    localparam int unsigned STAT_ERR_BIT  = 2;

    typedef enum logic [1:0] {
        MODE_OR   = 2'd0,
        MODE_AND  = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Starting accumulator value that leaves the first operand unchanged.
    function automatic logic [DATA_W-1:0] identity(mode_e m);
        return (m == MODE_AND) ? '1 : '0;
    endfunction

    // One reduction step.
    function automatic logic [DATA_W-1:0] apply(mode_e m, logic [DATA_W-1:0] a,
                                                logic [DATA_W-1:0] b);
        case (m)
            MODE_OR:  return a | b;
            MODE_AND: return a & b;
            MODE_XOR: return a ^ b;
            default:  return a;
        endcase
    endfunction

endpackage

// File: rtl/bitwise_accel.sv
// Memory-mapped OR/AND/XOR reduction over software-written operand registers.
module bitwise_accel
    import bitwise_accel_pkg::*;
#(
    parameter int unsigned NUM_OPS = 4,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        accel_req_i,
    input  logic        accel_we_i,
    input  logic [3:0]  accel_be_i,
    input  logic [31:0] accel_addr_i,
    input  logic [31:0] accel_wdata_i,
    output logic        accel_rvalid_o,
    output logic [31:0] accel_rdata_o,
    output logic        accel_irq_o
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    logic [DATA_W-1:0]  op_q [NUM_OPS];
    logic [DATA_W-1:0]  acc_q;
    logic [DATA_W-1:0]  result_q;
    logic [COUNT_W-1:0] idx_q;
    logic [COUNT_W-1:0] count_q;
    mode_e              mode_q;
    logic               irq_en_q;
    logic               done_q;
    logic               err_q;
    state_e             state_q;
    state_e             state_d;

    logic [ADDR_W-1:0]  off_c;
    logic [IDX_W-1:0]   word_c;
    logic [NUM_OPS-1:0] op_sel_c;
    logic [DATA_W-1:0]  rd_data_c;
    logic [DATA_W-1:0]  cur_op_c;
    logic               busy_c;
    logic               wr_c;
    logic               ctrl_wr_c;
    logic               status_wr_c;
    mode_e              mode_w_c;
    logic [COUNT_W-1:0] cnt_w_c;
    logic               cfg_legal_c;
    logic               start_req_c;
    logic               start_ok_c;
    logic               start_err_c;
    logic               last_c;
    logic               unused_c;

    assign off_c       = accel_addr_i[ADDR_W-1:0];
    assign word_c      = off_c[ADDR_W-1:2];
    assign unused_c    = ^{accel_addr_i[31:ADDR_W], accel_addr_i[1:0]};
    assign busy_c      = (state_q == RUN);
    assign wr_c        = accel_req_i & accel_we_i;
    assign ctrl_wr_c   = wr_c & (off_c == ADDR_W'(OFF_CTRL));
    assign status_wr_c = wr_c & (off_c == ADDR_W'(OFF_STATUS));
    assign mode_w_c    = mode_e'(accel_wdata_i[CTRL_MODE_LSB +: 2]);
    assign cnt_w_c     = accel_wdata_i[CTRL_COUNT_LSB +: COUNT_W];
    assign cfg_legal_c = (cnt_w_c != '0) && (cnt_w_c <= COUNT_W'(NUM_OPS))
                         && (mode_w_c != MODE_RSVD);
    assign start_req_c = ctrl_wr_c & accel_wdata_i[CTRL_START_BIT];
    assign start_ok_c  = start_req_c & ~busy_c & cfg_legal_c;
    assign start_err_c = start_req_c & (busy_c | ~cfg_legal_c);
    assign last_c      = busy_c && (idx_q == count_q - COUNT_W'(1));
    assign accel_irq_o = done_q & irq_en_q;

    // Address decode, read mux and current-operand select.
    always_comb begin
        op_sel_c  = '0;
        rd_data_c = '0;
        cur_op_c  = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            op_sel_c[i] = (word_c == IDX_W'(i));
            if (op_sel_c[i]) rd_data_c = op_q[i];
            if (idx_q == COUNT_W'(i)) cur_op_c = op_q[i];
        end
        if (off_c == ADDR_W'(OFF_CTRL))
            rd_data_c = DATA_W'({count_q, 4'b0, irq_en_q, mode_q, 1'b0});
        else if (off_c == ADDR_W'(OFF_STATUS))
            rd_data_c = DATA_W'({err_q, done_q, busy_c});
        else if (off_c == ADDR_W'(OFF_RESULT))
            rd_data_c = result_q;
    end

    // Operand register file with byte-enable writes, frozen while a run is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_OPS; i++) op_q[i] <= '0;
        end else if (wr_c && !busy_c) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (op_sel_c[i] && accel_be_i[b])
                        op_q[i][8*b +: 8] <= accel_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // CTRL fields; stored on any idle write even when the start itself is rejected.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q   <= MODE_OR;
            irq_en_q <= 1'b0;
            count_q  <= '0;
        end else if (ctrl_wr_c && !busy_c) begin
            mode_q   <= mode_w_c;
            irq_en_q <= accel_wdata_i[CTRL_IRQ_EN_BIT];
            count_q  <= cnt_w_c;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok_c) state_d = RUN;
            RUN:     if (last_c)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accumulator, index, result and sticky status; completion beats a done W1C.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (start_ok_c) begin
                acc_q <= identity(mode_w_c);
                idx_q <= '0;
            end else if (busy_c) begin
                acc_q <= apply(mode_q, acc_q, cur_op_c);
                idx_q <= idx_q + COUNT_W'(1);
            end
            if (last_c) result_q <= apply(mode_q, acc_q, cur_op_c);

            if (start_ok_c)
                done_q <= 1'b0;
            else if (last_c)
                done_q <= 1'b1;
            else if (status_wr_c && accel_wdata_i[STAT_DONE_BIT])
                done_q <= 1'b0;

            if (start_err_c)
                err_q <= 1'b1;
            else if (status_wr_c && accel_wdata_i[STAT_ERR_BIT])
                err_q <= 1'b0;
        end
    end

    // Bus response: one cycle after every request, data sampled at the request edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            accel_rvalid_o <= 1'b0;
            accel_rdata_o  <= '0;
        end else begin
            accel_rvalid_o <= accel_req_i;
            if (accel_req_i) accel_rdata_o <= rd_data_c;
        end
    end

endmodule

// File: tb/tb_bitwise_accel.sv
// Scoreboard bench for bitwise_accel: stimulus queues expected responses, monitor checks them.
module tb_bitwise_accel;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        accel_req_i = 1'b0;
    logic        accel_we_i = 1'b0;
    logic [3:0]  accel_be_i = 4'h0;
    logic [31:0] accel_addr_i = 32'h0;
    logic [31:0] accel_wdata_i = 32'h0;
    logic        accel_rvalid_o;
    logic [31:0] accel_rdata_o;
    logic        accel_irq_o;

    always #5 clk_i = ~clk_i;

    bitwise_accel #(.NUM_OPS(4), .ADDR_W(8)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .accel_req_i    (accel_req_i),
        .accel_we_i     (accel_we_i),
        .accel_be_i     (accel_be_i),
        .accel_addr_i   (accel_addr_i),
        .accel_wdata_i  (accel_wdata_i),
        .accel_rvalid_o (accel_rvalid_o),
        .accel_rdata_o  (accel_rdata_o),
        .accel_irq_o    (accel_irq_o)
    );

    typedef struct {
        logic        chk;
        logic [31:0] data;
        logic        irq;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic stim_timeout = 1'b0;
    logic timeout_seen = 1'b0;

    // Monitor: rvalid must track outstanding requests; each response checks irq and data.
    always @(negedge clk_i) begin
        exp_t e;
        logic exp_v;
        exp_v = (sb_q.size() != 0);
        checks++;
        if (accel_rvalid_o !== exp_v) begin
            errors++;
            $display("FAIL rvalid at %0t: got %b expected %b", $time, accel_rvalid_o, exp_v);
        end
        if (accel_rvalid_o === 1'b1 && exp_v) begin
            e = sb_q.pop_front();
            checks++;
            if (accel_irq_o !== e.irq) begin
                errors++;
                $display("FAIL %s irq: got %b expected %b", e.name, accel_irq_o, e.irq);
            end
            if (e.chk) begin
                checks++;
                if (accel_rdata_o !== e.data) begin
                    errors++;
                    $display("FAIL %s rdata: got %h expected %h", e.name, accel_rdata_o, e.data);
                end
            end
        end
        if (stim_timeout && !timeout_seen) begin
            timeout_seen = 1'b1;
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
        end
    end

    task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic chk, input logic [31:0] exp_d,
                       input logic exp_irq, input string name);
        exp_t e;
        @(negedge clk_i);
        accel_req_i   = 1'b1;
        accel_we_i    = we;
        accel_be_i    = be;
        accel_addr_i  = addr;
        accel_wdata_i = wd;
        @(posedge clk_i);
        #1;
        e.chk  = chk;
        e.data = exp_d;
        e.irq  = exp_irq;
        e.name = name;
        sb_q.push_back(e);
        accel_req_i = 1'b0;
        accel_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic exp_irq);
        bus(1'b1, addr, 4'hF, wd, 1'b0, 32'h0, exp_irq, "write");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_irq,
                      input string name);
        bus(1'b0, addr, 4'h0, 32'h0, 1'b1, exp_d, exp_irq, name);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        rd(32'h84, 32'h0, 1'b0, "rst_status");
        rd(32'h88, 32'h0, 1'b0, "rst_result");
        rd(32'h00, 32'h0, 1'b0, "rst_op0");
        rd(32'h80, 32'h0, 1'b0, "rst_ctrl");

        // OR reduction, count=4: busy on the four reads after the start, then done
        wr(32'h00, 32'h0000_0001, 1'b0);
        wr(32'h04, 32'h0000_0002, 1'b0);
        wr(32'h08, 32'h0000_0004, 1'b0);
        wr(32'h0C, 32'h8000_0000, 1'b0);
        rd(32'h0C, 32'h8000_0000, 1'b0, "or_op3");
        wr(32'h80, 32'h0000_0401, 1'b0);
        rd(32'h84, 32'h1, 1'b0, "or_busy1");
        rd(32'h84, 32'h1, 1'b0, "or_busy2");
        rd(32'h84, 32'h1, 1'b0, "or_busy3");
        rd(32'h84, 32'h1, 1'b0, "or_busy4");
        rd(32'h84, 32'h2, 1'b0, "or_done");
        rd(32'h88, 32'h8000_0007, 1'b0, "or_result");
        wr(32'h84, 32'h2, 1'b0);
        rd(32'h84, 32'h0, 1'b0, "or_w1c");

        // AND with interrupt, count=2
        wr(32'h00, 32'hFF00_FF00, 1'b0);
        wr(32'h04, 32'h0FF0_0FF0, 1'b0);
        wr(32'h80, 32'h0000_020B, 1'b0);
        rd(32'h84, 32'h1, 1'b0, "and_busy");
        rd(32'h84, 32'h1, 1'b1, "and_irq_rise");
        rd(32'h84, 32'h2, 1'b1, "and_done");
        rd(32'h88, 32'h0F00_0F00, 1'b1, "and_result");
        rd(32'h80, 32'h0000_020A, 1'b1, "and_ctrl");
        wr(32'h84, 32'h2, 1'b0);
        rd(32'h84, 32'h0, 1'b0, "and_irq_fall");
        wr(32'h80, 32'h0, 1'b0);

        // Byte-enable masking
        wr(32'h00, 32'h1122_3344, 1'b0);
        bus(1'b1, 32'h00, 4'b0101, 32'hAABB_CCDD, 1'b0, 32'h0, 1'b0, "be_write");
        rd(32'h00, 32'h11BB_33DD, 1'b0, "be_op0");

        // Illegal starts: count=0, count=NUM_OPS+1, mode=3
        wr(32'h80, 32'h0000_0001, 1'b0);
        rd(32'h84, 32'h4, 1'b0, "ill_cnt0");
        wr(32'h84, 32'h4, 1'b0);
        wr(32'h80, 32'h0000_0501, 1'b0);
        rd(32'h84, 32'h4, 1'b0, "ill_cnt5");
        wr(32'h84, 32'h4, 1'b0);
        wr(32'h80, 32'h0000_0407, 1'b0);
        rd(32'h84, 32'h4, 1'b0, "ill_mode3");
        rd(32'h88, 32'h0F00_0F00, 1'b0, "ill_result_kept");
        wr(32'h84, 32'h4, 1'b0);

        // XOR run with a start and an operand write issued while busy
        wr(32'h00, 32'h0000_0001, 1'b0);
        wr(32'h04, 32'h0000_0003, 1'b0);
        wr(32'h08, 32'h0000_0007, 1'b0);
        wr(32'h0C, 32'h0000_000F, 1'b0);
        wr(32'h80, 32'h0000_0405, 1'b0);
        wr(32'h04, 32'hFFFF_FFFF, 1'b0);
        wr(32'h80, 32'h0000_0401, 1'b0);
        rd(32'h84, 32'h5, 1'b0, "xor_busy_err");
        rd(32'h84, 32'h5, 1'b0, "xor_busy_last");
        rd(32'h84, 32'h6, 1'b0, "xor_done_err");
        rd(32'h88, 32'h0000_000A, 1'b0, "xor_result");
        rd(32'h04, 32'h0000_0003, 1'b0, "xor_op1_kept");
        rd(32'h80, 32'h0000_0404, 1'b0, "xor_ctrl_kept");

        // Reset two cycles into a count=4 run, with done/err still set from before
        wr(32'h80, 32'h0000_0401, 1'b0);
        @(negedge clk_i);
        do_reset();
        rd(32'h84, 32'h0, 1'b0, "mid_rst_status");
        rd(32'h88, 32'h0, 1'b0, "mid_rst_result");
        rd(32'h00, 32'h0, 1'b0, "mid_rst_op0");
        rd(32'h04, 32'h0, 1'b0, "mid_rst_op1");
        rd(32'h08, 32'h0, 1'b0, "mid_rst_op2");
        rd(32'h0C, 32'h0, 1'b0, "mid_rst_op3");
        rd(32'h80, 32'h0, 1'b0, "mid_rst_ctrl");

        // Back-to-back reads and unmapped offsets
        wr(32'h10, 32'hDEAD_BEEF, 1'b0);
        rd(32'h84, 32'h0, 1'b0, "b2b_status");
        rd(32'h88, 32'h0, 1'b0, "b2b_result");
        rd(32'hFC, 32'h0, 1'b0, "b2b_unmapped");
        rd(32'h10, 32'h0, 1'b0, "op4_unmapped");

        // count=1 boundary, then back-to-back start in the first idle cycle
        wr(32'h00, 32'h0000_005A, 1'b0);
        wr(32'h80, 32'h0000_0101, 1'b0);
        rd(32'h84, 32'h1, 1'b0, "cnt1_busy");
        wr(32'h80, 32'h0000_0103, 1'b0);
        rd(32'h84, 32'h1, 1'b0, "b2b_start_busy");
        rd(32'h84, 32'h2, 1'b0, "b2b_start_done");
        rd(32'h88, 32'h0000_005A, 1'b0, "cnt1_result");

        for (int i = 0; i < 10; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk_i);
        end
        if (sb_q.size() != 0) stim_timeout = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
